// File: rtl/cic3_row_pkg.sv
// Shared widths, FSM state type and bus helpers
// for the CIC3 filter-row readout scheduler.
package cic3_row_pkg;

    localparam int NUM_FILTERS = 24;
    localparam int OUT_WIDTH   = 25;
    localparam int CHAN_W      = $clog2(NUM_FILTERS);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic logic [OUT_WIDTH-1:0] chan_word(
        input logic [NUM_FILTERS*OUT_WIDTH-1:0] bus,
        input logic [CHAN_W-1:0]                k
    );
        return bus[int'(k)*OUT_WIDTH +: OUT_WIDTH];
    endfunction

endpackage

// File: rtl/cic3_row_ffs.sv
// Find-first-set over a channel vector: lowest set index,
// any-set flag, and whether exactly one bit remains.
module cic3_row_ffs #(
    parameter int N  = 24,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] index,
    output logic          any,
    output logic          onehot_last
);

    always_comb begin
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) index = IW'(i);
        end
    end

    assign any         = |vec;
    assign onehot_last = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/cic3_row_readout_sched.sv
// Decimation tick generator and snapshot/drain scheduler
// for one row of CIC3 filters onto a tagged valid/ready stream.
module cic3_row_readout_sched #(
    parameter int NUM_FILTERS = cic3_row_pkg::NUM_FILTERS,
    parameter int OUT_WIDTH   = cic3_row_pkg::OUT_WIDTH,
    parameter int DECIMATION  = 64,
    parameter int CHAN_W      = $clog2(NUM_FILTERS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_FILTERS-1:0]         chan_mask,
    input  logic [NUM_FILTERS*OUT_WIDTH-1:0] filt_out,
    output logic [OUT_WIDTH-1:0]           dout_data,
    output logic [CHAN_W-1:0]              dout_chan,
    output logic                           dout_valid,
    input  logic                           dout_ready,
    output logic                           dout_last,
    output logic [15:0]                    frame_cnt,
    output logic                           overrun,
    input  logic                           overrun_clr
);
    import cic3_row_pkg::*;

    localparam int DW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

    logic [DW-1:0]          dcnt;
    state_t                 state;
    logic [NUM_FILTERS-1:0] pending;
    logic [NUM_FILTERS-1:0] mask_q;
    logic [NUM_FILTERS-1:0] pending_nx;
    logic [OUT_WIDTH-1:0]   snap [NUM_FILTERS];

    logic                   tick;
    logic                   hs;
    logic                   accept;
    logic                   drop;
    logic [CHAN_W-1:0]      nx_idx;
    logic                   nx_any;
    logic                   nx_last;
    logic [OUT_WIDTH-1:0]   nx_data;

    assign tick   = enable && (dcnt == DW'(DECIMATION - 1));
    assign hs     = dout_valid && dout_ready;
    assign accept = tick && (state == IDLE || (hs && dout_last));
    assign drop   = tick && !accept;

    // Next pending set drives the registered outputs, so the word
    // presented after each edge is already the correct one.
    always_comb begin
        pending_nx = pending & mask_q;
        if (hs) pending_nx[dout_chan] = 1'b0;
        if (accept) pending_nx = chan_mask;
    end

    cic3_row_ffs #(
        .N  (NUM_FILTERS),
        .IW (CHAN_W)
    ) u_ffs (
        .vec         (pending_nx),
        .index       (nx_idx),
        .any         (nx_any),
        .onehot_last (nx_last)
    );

    assign nx_data = accept ? chan_word(filt_out, nx_idx)
                            : snap[nx_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt       <= '0;
            state      <= IDLE;
            pending    <= '0;
            mask_q     <= '0;
            frame_cnt  <= '0;
            overrun    <= 1'b0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_chan  <= '0;
            dout_last  <= 1'b0;
        end else begin
            dcnt <= (!enable || tick) ? '0 : dcnt + DW'(1);
            if (accept) begin
                mask_q    <= chan_mask;
                frame_cnt <= frame_cnt + 16'd1;
            end
            pending    <= pending_nx;
            state      <= nx_any ? SCAN : IDLE;
            overrun    <= drop | (overrun & ~overrun_clr);
            dout_valid <= nx_any;
            dout_data  <= nx_any ? nx_data : '0;
            dout_chan  <= nx_any ? nx_idx : '0;
            dout_last  <= nx_last;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NUM_FILTERS; k++) begin
                snap[k] <= chan_word(filt_out, CHAN_W'(k));
            end
        end
    end

endmodule

// File: tb/tb_cic3_row_readout_sched.sv
// Randomized and directed bench for cic3_row_readout_sched
// against a frame-queue reference model.
module tb_cic3_row_readout_sched;

    localparam int NF  = 24;
    localparam int OW  = 25;
    localparam int CW  = 5;
    localparam int DEC = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NF-1:0]     chan_mask;
    logic [NF*OW-1:0]  filt_out;
    logic [OW-1:0]     dout_data;
    logic [CW-1:0]     dout_chan;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;
    logic [15:0]       frame_cnt;
    logic              overrun;
    logic              overrun_clr;

    cic3_row_readout_sched #(
        .DECIMATION (DEC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .chan_mask   (chan_mask),
        .filt_out    (filt_out),
        .dout_data   (dout_data),
        .dout_chan   (dout_chan),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_last   (dout_last),
        .frame_cnt   (frame_cnt),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int chan;
        int data;
    } word_t;

    word_t q[$];
    int    m_cnt;
    int    m_fc;
    int    m_ov;
    int    n_checks;
    int    n_errors;

    logic          s_valid;
    logic [OW-1:0] s_data;
    logic [CW-1:0] s_chan;
    logic          s_last;
    logic [15:0]   s_fc;
    logic          s_ov;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: compare at negedge, advance the model, return after posedge.
    task automatic cycle();
        bit ev;
        bit hs;
        bit tk;
        bit acc;
        @(negedge clk);
        s_valid = dout_valid;
        s_data  = dout_data;
        s_chan  = dout_chan;
        s_last  = dout_last;
        s_fc    = frame_cnt;
        s_ov    = overrun;
        ev = (q.size() > 0);
        chk("valid", 32'(dout_valid), 32'(ev));
        if (ev) begin
            chk("data", 32'(dout_data), q[0].data);
            chk("chan", 32'(dout_chan), q[0].chan);
            chk("last", 32'(dout_last), 32'(q.size() == 1));
        end
        chk("frame_cnt", 32'(frame_cnt), m_fc & 32'hFFFF);
        chk("overrun", 32'(overrun), m_ov);
        if (reset) begin
            q.delete();
            m_cnt = 0;
            m_fc  = 0;
            m_ov  = 0;
        end else begin
            hs  = ev && dout_ready;
            tk  = enable && (m_cnt == DEC - 1);
            acc = tk && (q.size() == 0 || (hs && q.size() == 1));
            if (hs) void'(q.pop_front());
            if (acc) begin
                m_fc++;
                for (int k = 0; k < NF; k++) begin
                    if (chan_mask[k])
                        q.push_back('{k, int'(filt_out[k*OW +: OW])});
                end
            end
            if (tk && !acc) m_ov = 1;
            else if (overrun_clr) m_ov = 0;
            m_cnt = enable ? (m_cnt + 1) % DEC : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic filt_seq();
        for (int k = 0; k < NF; k++)
            filt_out[k*OW +: OW] = OW'(k + 'h100);
    endtask

    task automatic filt_rand();
        for (int k = 0; k < NF; k++)
            filt_out[k*OW +: OW] = OW'($urandom);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        cycle();
        reset  = 1'b0;
    endtask

    int   n;
    logic [OW-1:0] d0;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        m_cnt       = 0;
        m_fc        = 0;
        m_ov        = 0;
        reset       = 1'b1;
        enable      = 1'b0;
        dout_ready  = 1'b0;
        chan_mask   = '0;
        filt_out    = '0;
        overrun_clr = 1'b0;

        cycle();
        cycle();
        chk("rst_valid", 32'(s_valid), 0);
        chk("rst_data", 32'(s_data), 0);
        chk("rst_chan", 32'(s_chan), 0);
        chk("rst_last", 32'(s_last), 0);
        chk("rst_fc", 32'(s_fc), 0);
        chk("rst_ov", 32'(s_ov), 0);

        // full mask, continuous ready
        reset      = 1'b0;
        chan_mask  = '1;
        dout_ready = 1'b1;
        filt_seq();
        enable     = 1'b1;
        repeat (8) cycle();
        cycle();
        chk("s1_first_data", 32'(s_data), 'h100);
        chk("s1_first_chan", 32'(s_chan), 0);
        chk("s1_fc", 32'(s_fc), 1);
        repeat (8) cycle();
        chk("s1_overrun", 32'(s_ov), 1);
        repeat (15) cycle();
        chk("s1_last_chan", 32'(s_chan), 23);
        chk("s1_last_flag", 32'(s_last), 1);
        chk("s1_last_data", 32'(s_data), 'h117);

        // sparse mask
        do_reset();
        chan_mask = 24'h000811;
        filt_rand();
        enable    = 1'b1;
        repeat (17) cycle();
        chk("s2_fc", 32'(s_fc), 2);
        chk("s2_ov", 32'(s_ov), 0);

        // stall with mid-scan input changes
        do_reset();
        chan_mask  = 24'h000003;
        dout_ready = 1'b0;
        filt_rand();
        enable     = 1'b1;
        repeat (9) cycle();
        d0 = s_data;
        chk("s3_valid", 32'(s_valid), 1);
        for (int i = 0; i < 4; i++) begin
            filt_rand();
            chan_mask = NF'($urandom);
            cycle();
            chk("s3_hold_data", 32'(s_data), 32'(d0));
            chk("s3_hold_chan", 32'(s_chan), 0);
        end
        dout_ready = 1'b1;
        cycle();
        cycle();
        chk("s3_second_chan", 32'(s_chan), 1);

        // empty mask
        do_reset();
        chan_mask = '0;
        enable    = 1'b1;
        repeat (25) cycle();
        chk("s4_fc", 32'(s_fc), 3);
        chk("s4_valid", 32'(s_valid), 0);
        chk("s4_ov", 32'(s_ov), 0);

        // final handshake on a tick, then clear racing a dropped tick
        do_reset();
        chan_mask  = 24'hFF0000;
        dout_ready = 1'b1;
        filt_rand();
        enable     = 1'b1;
        repeat (17) cycle();
        chk("s5_valid", 32'(s_valid), 1);
        chk("s5_chan", 32'(s_chan), 16);
        chk("s5_ov", 32'(s_ov), 0);
        chk("s5_fc", 32'(s_fc), 2);
        dout_ready = 1'b0;
        for (int i = 0; i < DEC && m_cnt != DEC - 1; i++) cycle();
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        cycle();
        chk("s5_set_wins", 32'(s_ov), 1);
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        cycle();
        chk("s5_cleared", 32'(s_ov), 0);

        // random traffic
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 400; i++) begin
            dout_ready  = ($urandom % 4) != 0;
            chan_mask   = NF'($urandom & $urandom);
            overrun_clr = ($urandom % 16) == 0;
            enable      = ($urandom % 64) != 0;
            reset       = ($urandom % 200) == 0;
            filt_rand();
            cycle();
        end
        reset       = 1'b0;
        overrun_clr = 1'b0;

        // reset mid-scan, then first-tick latency
        do_reset();
        chan_mask  = '1;
        dout_ready = 1'b1;
        filt_rand();
        enable     = 1'b1;
        repeat (12) cycle();
        reset  = 1'b1;
        enable = 1'b0;
        cycle();
        reset = 1'b0;
        cycle();
        chk("s6_valid", 32'(s_valid), 0);
        chk("s6_data", 32'(s_data), 0);
        chk("s6_chan", 32'(s_chan), 0);
        chk("s6_last", 32'(s_last), 0);
        chk("s6_fc", 32'(s_fc), 0);
        chk("s6_ov", 32'(s_ov), 0);
        enable = 1'b1;
        for (n = 1; n <= 20; n++) begin
            cycle();
            if (s_valid) break;
        end
        chk("s6_first_tick", n, 9);
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
